// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI block reader.
package sd_spi_pkg;

  // Block-read sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    R1     = 3'd2,
    TOKEN  = 3'd3,
    DATA   = 3'd4,
    CRC    = 3'd5,
    FINISH = 3'd6
  } state_e;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned CMD_BYTES   = 6;
  localparam int unsigned CRC_BYTES   = 2;
  localparam int unsigned ERR_W       = 3;

  localparam logic [7:0] CMD17_BYTE    = 8'h51;
  localparam logic [7:0] CMD_CRC_STOP  = 8'h01;
  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  localparam logic [ERR_W-1:0] ERR_OK       = 3'd0;
  localparam logic [ERR_W-1:0] ERR_R1       = 3'd1;
  localparam logic [ERR_W-1:0] ERR_R1_TO    = 3'd2;
  localparam logic [ERR_W-1:0] ERR_TOKEN    = 3'd3;
  localparam logic [ERR_W-1:0] ERR_TOKEN_TO = 3'd4;

  // Byte idx of the six-byte CMD17 frame: command, 32-bit argument MSB first, CRC/stop.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] arg);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD17_BYTE;
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = CMD_CRC_STOP;
      default: b = SPI_IDLE_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_byte_issuer.sv
// Single-outstanding byte handshake towards the SPI byte engine.
module sd_spi_byte_issuer
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic [7:0] tx_byte_i,
  input  logic       spi_tx_ready_i,
  input  logic       spi_rx_dv_i,
  input  logic [7:0] spi_rx_byte_i,
  output logic       spi_tx_dv_o,
  output logic [7:0] spi_tx_byte_o,
  output logic       rx_strobe_c,
  output logic [7:0] rx_byte_c
);

  logic       outstanding_q, outstanding_d;
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       fire_c;

  // Launch when the engine is idle and nothing is in flight; rx only counts while a byte is owed.
  always_comb begin
    fire_c        = 1'b0;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    outstanding_d = outstanding_q;
    rx_strobe_c   = spi_rx_dv_i && outstanding_q;
    rx_byte_c     = spi_rx_byte_i;
    if (req_i && spi_tx_ready_i && !outstanding_q && !tx_dv_q) begin
      fire_c = 1'b1;
    end
    if (fire_c) begin
      tx_dv_d       = 1'b1;
      tx_byte_d     = tx_byte_i;
      outstanding_d = 1'b1;
    end else if (rx_strobe_c) begin
      outstanding_d = 1'b0;
    end
  end

  // Handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= 1'b0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= SPI_IDLE_BYTE;
    end else begin
      outstanding_q <= outstanding_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
    end
  end

  assign spi_tx_dv_o   = tx_dv_q;
  assign spi_tx_byte_o = tx_byte_q;

endmodule

// File: rtl/sd_spi_block_reader.sv
// Reads one 512-byte SD block over SPI (CMD17) and streams the data bytes out.
module sd_spi_block_reader
  import sd_spi_pkg::*;
#(
  parameter int unsigned R1_TIMEOUT    = 8,
  parameter int unsigned TOKEN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_start,
  input  logic [31:0]       rd_lba,
  input  logic              sdhc,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [ERR_W-1:0]  rd_err,
  output logic              data_valid,
  output logic [7:0]        data_byte,
  output logic [ADDR_W-1:0] data_addr,
  output logic              cs_n,
  output logic [7:0]        spi_tx_byte,
  output logic              spi_tx_dv,
  input  logic              spi_tx_ready,
  input  logic              spi_rx_dv,
  input  logic [7:0]        spi_rx_byte
);

  localparam int unsigned POLL_MAX = (TOKEN_TIMEOUT > R1_TIMEOUT) ? TOKEN_TIMEOUT : R1_TIMEOUT;
  localparam int unsigned PW       = $clog2(POLL_MAX + 1);

  state_e             state_q, state_d;
  logic [31:0]        arg_q, arg_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]      poll_cnt_q, poll_cnt_d;
  logic               cs_n_q, cs_n_d;
  logic               rd_busy_q, rd_busy_d;
  logic               rd_done_q, rd_done_d;
  logic [ERR_W-1:0]   rd_err_q, rd_err_d;
  logic               data_valid_q, data_valid_d;
  logic [7:0]         data_byte_q, data_byte_d;
  logic [ADDR_W-1:0]  data_addr_q, data_addr_d;

  logic               req_c;
  logic [7:0]         tx_byte_c;
  logic               rx_strobe_c;
  logic [7:0]         rx_byte_c;

  sd_spi_byte_issuer u_issuer (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req_c),
    .tx_byte_i      (tx_byte_c),
    .spi_tx_ready_i (spi_tx_ready),
    .spi_rx_dv_i    (spi_rx_dv),
    .spi_rx_byte_i  (spi_rx_byte),
    .spi_tx_dv_o    (spi_tx_dv),
    .spi_tx_byte_o  (spi_tx_byte),
    .rx_strobe_c    (rx_strobe_c),
    .rx_byte_c      (rx_byte_c)
  );

  // Next-state, counters and output register inputs; every transition is paced by a received byte.
  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    err_d        = err_q;
    byte_cnt_d   = byte_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    rd_busy_d    = rd_busy_q;
    rd_done_d    = 1'b0;
    rd_err_d     = rd_err_q;
    data_valid_d = 1'b0;
    data_byte_d  = data_byte_q;
    data_addr_d  = data_addr_q;
    req_c        = (state_q != IDLE);
    tx_byte_c    = SPI_IDLE_BYTE;

    // Busy stays up through the rd_done cycle so a coincident rd_start is ignored.
    if (rd_done_q) begin
      rd_busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rd_start && !rd_busy_q) begin
          arg_d      = sdhc ? rd_lba : {rd_lba[22:0], 9'd0};
          err_d      = ERR_OK;
          rd_err_d   = ERR_OK;
          rd_busy_d  = 1'b1;
          byte_cnt_d = '0;
          poll_cnt_d = '0;
          state_d    = CMD;
        end
      end

      CMD: begin
        tx_byte_c = cmd_byte(byte_cnt_q[2:0], arg_q);
        if (rx_strobe_c) begin
          if (byte_cnt_q == ADDR_W'(CMD_BYTES - 1)) begin
            byte_cnt_d = '0;
            poll_cnt_d = '0;
            state_d    = R1;
          end else begin
            byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          end
        end
      end

      R1: begin
        if (rx_strobe_c) begin
          if (!rx_byte_c[7]) begin
            if (rx_byte_c == 8'h00) begin
              poll_cnt_d = '0;
              state_d    = TOKEN;
            end else begin
              err_d   = ERR_R1;
              state_d = FINISH;
            end
          end else if (poll_cnt_q == PW'(R1_TIMEOUT - 1)) begin
            err_d   = ERR_R1_TO;
            state_d = FINISH;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
          end
        end
      end

      TOKEN: begin
        if (rx_strobe_c) begin
          if (rx_byte_c == TOKEN_START) begin
            byte_cnt_d = '0;
            state_d    = DATA;
          end else if (rx_byte_c != SPI_IDLE_BYTE) begin
            err_d   = ERR_TOKEN;
            state_d = FINISH;
          end else if (poll_cnt_q == PW'(TOKEN_TIMEOUT - 1)) begin
            err_d   = ERR_TOKEN_TO;
            state_d = FINISH;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
          end
        end
      end

      DATA: begin
        if (rx_strobe_c) begin
          data_valid_d = 1'b1;
          data_byte_d  = rx_byte_c;
          data_addr_d  = byte_cnt_q;
          byte_cnt_d   = byte_cnt_q + ADDR_W'(1);
          if (byte_cnt_q == ADDR_W'(BLOCK_BYTES - 1)) begin
            state_d = CRC;
          end
        end
      end

      CRC: begin
        if (rx_strobe_c) begin
          if (byte_cnt_q == ADDR_W'(CRC_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = FINISH;
          end else begin
            byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          end
        end
      end

      FINISH: begin
        if (rx_strobe_c) begin
          rd_done_d = 1'b1;
          rd_err_d  = err_q;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Card deselected before the trailing byte so it sees 8 clocks with CS high.
    cs_n_d = (state_d == IDLE) || (state_d == FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      arg_q        <= '0;
      err_q        <= ERR_OK;
      byte_cnt_q   <= '0;
      poll_cnt_q   <= '0;
      cs_n_q       <= 1'b1;
      rd_busy_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_err_q     <= ERR_OK;
      data_valid_q <= 1'b0;
      data_byte_q  <= '0;
      data_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      arg_q        <= arg_d;
      err_q        <= err_d;
      byte_cnt_q   <= byte_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      cs_n_q       <= cs_n_d;
      rd_busy_q    <= rd_busy_d;
      rd_done_q    <= rd_done_d;
      rd_err_q     <= rd_err_d;
      data_valid_q <= data_valid_d;
      data_byte_q  <= data_byte_d;
      data_addr_q  <= data_addr_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign rd_busy    = rd_busy_q;
  assign rd_done    = rd_done_q;
  assign rd_err     = rd_err_q;
  assign data_valid = data_valid_q;
  assign data_byte  = data_byte_q;
  assign data_addr  = data_addr_q;

endmodule

// File: doc/sd_spi_block_reader.md
Name: sd_spi_block_reader

Overview:
- Sequences the byte-level SPI master engine to read one 512-byte block from an SD card in SPI mode: CMD17, R1 poll, start-token poll, data, CRC, trailing clocks.
- Streams received data bytes to a buffer writer (BRAM or FIFO) so the CPU does not issue 500+ individual byte transfers per sector.
- Sits between the iosys register front-end, which drives rd_start and rd_lba, and the SPI byte engine, for which it is the sole requester.

Parameters:
- R1_TIMEOUT, 8: maximum 0xFF poll bytes sent while waiting for R1.
- TOKEN_TIMEOUT, 4096: maximum poll bytes sent while waiting for the data start token.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_start  in  1  one-cycle pulse; starts a block read. Ignored while rd_busy=1.
- rd_lba  in  32  block number; sampled on the rd_start cycle.
- sdhc  in  1  1: block addressing (arg=lba). 0: byte addressing (arg=lba<<9, truncated to 32 bits). Sampled with rd_start.
- rd_busy  out  1  high from the cycle after the accepted rd_start until the cycle of rd_done.
- rd_done  out  1  one-cycle pulse at the end of the read, on success or error.
- rd_err  out  3  result code, valid with rd_done and held until the next accepted rd_start. 0=ok, 1=R1 nonzero, 2=R1 timeout, 3=data error token, 4=token timeout.
- data_valid  out  1  one-cycle pulse per data byte.
- data_byte  out  8  data byte; valid with data_valid.
- data_addr  out  9  byte index 0..511; valid with data_valid.
- cs_n  out  1  SD chip select, active low.
- spi_tx_byte  out  8  byte for the SPI engine to send.
- spi_tx_dv  out  1  one-cycle start pulse to the SPI engine.
- spi_tx_ready  in  1  SPI engine idle.
- spi_rx_dv  in  1  received byte valid.
- spi_rx_byte  in  8  received byte.

Behaviour:
- Reset values (asynchronous, reset=1):
  - state=IDLE, cs_n=1, spi_tx_dv=0, spi_tx_byte=0xFF.
  - rd_busy=0, rd_done=0, rd_err=0.
  - data_valid=0, data_byte=0, data_addr=0.
  - Poll and byte counters = 0.
- Byte handshake:
  - At most one transfer outstanding.
  - spi_tx_dv pulses for one cycle only when spi_tx_ready=1, the outstanding flag is clear, and spi_tx_dv was 0 on the previous cycle.
  - Setting spi_tx_dv sets the outstanding flag. spi_rx_dv clears it and delivers spi_rx_byte to the state machine in that same cycle.
  - spi_rx_dv while no transfer is outstanding (for example after a reset mid-byte) is ignored.
- State machine:
  - IDLE: on rd_start, latch arg = sdhc ? rd_lba : rd_lba<<9, clear rd_err, set rd_busy, go to CMD.
  - CMD: cs_n=0. Send 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0x01 (six transfers; received bytes discarded). Go to R1.
  - R1: send 0xFF per poll.
    - rx bit7=0 and rx=0x00: go to TOKEN.
    - rx bit7=0 and rx nonzero: err=1, go to FINISH.
    - Otherwise, after R1_TIMEOUT polls: err=2, go to FINISH.
  - TOKEN: send 0xFF per poll.
    - rx=0xFE: go to DATA.
    - rx other than 0xFF and 0xFE: err=3, go to FINISH.
    - Otherwise, after TOKEN_TIMEOUT polls: err=4, go to FINISH.
  - DATA: 512 transfers of 0xFF.
    - On each spi_rx_dv: data_valid=1 in the next cycle, with data_byte=rx and data_addr=count.
    - count wraps 511->0 on the last byte, then go to CRC.
  - CRC: two 0xFF transfers, received bytes discarded. Go to FINISH.
  - FINISH: cs_n=1 first, then one 0xFF transfer (8 trailing clocks). On its spi_rx_dv: rd_done=1 for one cycle, rd_busy=0, rd_err=err, return to IDLE.
- Latency:
  - rd_busy rises 1 cycle after rd_start.
  - The first spi_tx_dv fires no earlier than 1 cycle after entering CMD.
  - rd_done fires 1 cycle after the FINISH byte's spi_rx_dv.
- Boundary conditions:
  - rd_start coincident with rd_done: ignored, because busy is still asserted that cycle.
  - Poll counters: poll number N with N == TIMEOUT failing the test triggers the timeout. Exactly TIMEOUT poll bytes are sent.
  - Reset mid-operation: cs_n goes to 1 immediately, with no rd_done and no data_valid. The byte in flight completes in the engine and its result is ignored.
  - No data_valid is emitted on any error path.

Decomposition:
- Package sd_spi_pkg:
  - state enum (IDLE, CMD, R1, TOKEN, DATA, CRC, FINISH).
  - constants CMD17_BYTE=8'h51, CMD_CRC_STOP=8'h01, TOKEN_START=8'hFE, SPI_IDLE_BYTE=8'hFF.
  - error code constants ERR_OK..ERR_TOKEN_TO.
- Sub-module sd_spi_byte_issuer owns the handshake: the outstanding flag, spi_tx_dv generation and the rx delivery strobe.
- The FSM, counters and output registers stay in sd_spi_block_reader.

Test Plan:
- Happy path: SDHC card model, rd_lba=0x00001234, R1=0x00 after 2 polls, token 0xFE after 10 polls, data byte i = i[7:0] -> MOSI carries 51 00 00 12 34 01; 512 data_valid pulses with data_addr 0..511 and data_byte=i[7:0]; rd_done with rd_err=0; cs_n high before the last byte.
- Byte addressing: sdhc=0, rd_lba=0x00000003 -> arg bytes 00 00 06 00.
- R1 error: model returns 0x04 -> rd_err=1, no data_valid, cs_n=1, one trailing byte, rd_done.
- Timeouts: model never answers R1 (all 0xFF), R1_TIMEOUT=8 -> exactly 8 poll bytes, then rd_err=2. Never sends a token, TOKEN_TIMEOUT=16 -> 16 polls, then rd_err=4.
- Data error token: model sends 0x08 in place of 0xFE -> rd_err=3, no data_valid.
- Robustness: rd_start pulses during busy are ignored (exactly one rd_done). Reset asserted during DATA byte 100 -> cs_n=1 immediately, no rd_done; a subsequent read succeeds from data_addr 0.
